// File: rtl/s420_ctrl_pkg.sv
// rtl/s420_ctrl_pkg.sv - shared types and defaults for the s420 sweep controller
package s420_ctrl_pkg;

  localparam int S420_CNT_W  = 16;
  localparam int S420_MASK_W = 17;
  localparam int S420_HITS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                   hit;
    logic [S420_CNT_W-1:0]  first;
    logic [S420_HITS_W-1:0] hits;
    logic                   aborted;
  } res_t;

  function automatic logic [S420_HITS_W-1:0] sat_inc(input logic [S420_HITS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/s420_sweep_budget.sv
// rtl/s420_sweep_budget.sv - remaining-cycle down-counter and RUN index up-counter
module s420_sweep_budget #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] budget_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             last_o
);

  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  always_comb begin
    remaining_d = remaining_q;
    idx_d       = idx_q;
    if (load_i) begin
      remaining_d = budget_i;
      idx_d       = '0;
    end else if (step_i) begin
      remaining_d = remaining_q - 1'b1;
      idx_d       = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining_q <= '0;
      idx_q       <= '0;
    end else begin
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (remaining_q == CNT_W'(1));

endmodule

// File: rtl/s420_sweep_ctrl.sv
// rtl/s420_sweep_ctrl.sv - sweep sequencer driving s420 compare vector and count enable
module s420_sweep_ctrl
  import s420_ctrl_pkg::*;
#(
  parameter int CNT_W  = S420_CNT_W,
  parameter int MASK_W = S420_MASK_W,
  parameter int HITS_W = S420_HITS_W
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MASK_W-1:0] cmd_mask,
  input  logic [CNT_W-1:0]  cmd_budget,
  input  logic              cmd_stop_on_hit,
  input  logic              abort,
  output logic              ctr_en,
  output logic [MASK_W-1:0] ctr_cmp,
  input  logic              ctr_z,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [CNT_W-1:0]  res_first,
  output logic [HITS_W-1:0] res_hits,
  output logic              res_aborted
);

  state_e            state_q, state_d;
  logic              ctr_en_q, ctr_en_d;
  logic [MASK_W-1:0] ctr_cmp_q, ctr_cmp_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic              stop_q, stop_d;
  res_t              res_q, res_d;

  logic              cnt_load;
  logic              cnt_step;
  logic [CNT_W-1:0]  idx;
  logic              last;

  s420_sweep_budget #(.CNT_W(CNT_W)) u_budget (
    .clk_i   (CK),
    .rst_ni  (RN),
    .load_i  (cnt_load),
    .step_i  (cnt_step),
    .budget_i(budget_q),
    .idx_o   (idx),
    .last_o  (last)
  );

  always_comb begin
    state_d   = state_q;
    ctr_en_d  = ctr_en_q;
    ctr_cmp_d = ctr_cmp_q;
    budget_d  = budget_q;
    stop_d    = stop_q;
    res_d     = res_q;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ctr_cmp_d = cmd_mask;
          budget_d  = cmd_budget;
          stop_d    = cmd_stop_on_hit;
          res_d     = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          res_d.aborted = 1'b1;
          state_d       = ST_DONE;
        end else if (budget_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ctr_en_d = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_step = 1'b1;
        // The exit cycle's Z is still counted, so statistics update before the exit test.
        if (ctr_z) begin
          res_d.hits = sat_inc(res_q.hits);
          if (!res_q.hit) begin
            res_d.hit   = 1'b1;
            res_d.first = idx;
          end
        end
        if (abort || last || (stop_q && ctr_z)) begin
          ctr_en_d      = 1'b0;
          res_d.aborted = abort;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      ctr_en_q  <= 1'b0;
      ctr_cmp_q <= '0;
      budget_q  <= '0;
      stop_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctr_en_q  <= ctr_en_d;
      ctr_cmp_q <= ctr_cmp_d;
      budget_q  <= budget_d;
      stop_q    <= stop_d;
      res_q     <= res_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign res_valid   = (state_q == ST_DONE);
  assign ctr_en      = ctr_en_q;
  assign ctr_cmp     = ctr_cmp_q;
  assign res_hit     = res_q.hit;
  assign res_first   = res_q.first;
  assign res_hits    = res_q.hits;
  assign res_aborted = res_q.aborted;

endmodule

// File: tb/tb_s420_sweep_ctrl.sv
// tb/tb_s420_sweep_ctrl.sv - randomized self-checking bench for s420_sweep_ctrl
module tb_s420_sweep_ctrl;

  localparam int CNT_W  = 16;
  localparam int MASK_W = 17;
  localparam int HITS_W = 8;

  logic              CK = 1'b0;
  logic              RN;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [MASK_W-1:0] cmd_mask;
  logic [CNT_W-1:0]  cmd_budget;
  logic              cmd_stop_on_hit;
  logic              abort;
  logic              ctr_en;
  logic [MASK_W-1:0] ctr_cmp;
  logic              ctr_z;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [CNT_W-1:0]  res_first;
  logic [HITS_W-1:0] res_hits;
  logic              res_aborted;

  int n_chk  = 0;
  int n_fail = 0;
  bit z_pat [0:511];

  always #5 CK = ~CK;

  s420_sweep_ctrl dut (
    .CK             (CK),
    .RN             (RN),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mask       (cmd_mask),
    .cmd_budget     (cmd_budget),
    .cmd_stop_on_hit(cmd_stop_on_hit),
    .abort          (abort),
    .ctr_en         (ctr_en),
    .ctr_cmp        (ctr_cmp),
    .ctr_z          (ctr_z),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_hit        (res_hit),
    .res_first      (res_first),
    .res_hits       (res_hits),
    .res_aborted    (res_aborted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_pat(input bit v);
    for (int i = 0; i < 512; i++) z_pat[i] = v;
  endtask

  // Z for RUN index i is z_pat[i]; abort is raised in RUN index ab_idx (-1 = never)
  // or in the LOAD cycle when ab_load is set.
  task automatic run_sweep(input logic [MASK_W-1:0] mask, input int b, input bit stop,
                           input bit ab_load, input int ab_idx, input string tag);
    int exp_en, exp_hits, exp_first, cyc, en_cnt, k, first_en;
    bit exp_hit, exp_ab, got_valid, done_m;
    exp_en = 0; exp_hits = 0; exp_first = 0; exp_hit = 0; exp_ab = 0;
    if (ab_load) begin
      exp_ab = 1;
    end else begin
      exp_en = b;
      done_m = 0;
      for (int i = 0; i < b && !done_m; i++) begin
        if (z_pat[i]) begin
          if (!exp_hit) begin exp_hit = 1; exp_first = i; end
          if (exp_hits < 255) exp_hits++;
        end
        if (i == ab_idx) begin exp_ab = 1; exp_en = i + 1; done_m = 1; end
        else if (stop && z_pat[i]) begin exp_en = i + 1; done_m = 1; end
      end
    end

    @(negedge CK);
    chk({tag, ":cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid       = 1'b1;
    cmd_mask        = mask;
    cmd_budget      = b[CNT_W-1:0];
    cmd_stop_on_hit = stop;
    abort           = 1'($urandom_range(0, 1));
    ctr_z           = 1'($urandom_range(0, 1));
    res_ready       = 1'($urandom_range(0, 1));

    @(negedge CK);
    cyc = 1;
    chk({tag, ":busy_load"}, busy, 1);
    chk({tag, ":en_load"}, ctr_en, 0);
    chk({tag, ":cmp_load"}, ctr_cmp, mask);
    cmd_valid       = 1'b0;
    cmd_mask        = MASK_W'($urandom);
    cmd_budget      = CNT_W'($urandom);
    cmd_stop_on_hit = 1'($urandom_range(0, 1));
    abort           = ab_load;
    ctr_z           = 1'($urandom_range(0, 1));
    res_ready       = 1'b0;

    en_cnt = 0; k = 0; first_en = 0; got_valid = 0;
    while (cyc < b + 8) begin
      @(negedge CK);
      cyc++;
      if (res_valid) begin
        got_valid = 1;
        break;
      end
      if (ctr_en) begin
        if (en_cnt == 0) first_en = cyc;
        en_cnt++;
        ctr_z = z_pat[k];
        abort = (k == ab_idx);
        k++;
      end else begin
        ctr_z = 1'($urandom_range(0, 1));
        abort = 1'b0;
      end
    end

    chk({tag, ":res_valid"}, got_valid, 1);
    chk({tag, ":valid_cycle"}, cyc, 2 + exp_en);
    chk({tag, ":en_cycles"}, en_cnt, exp_en);
    if (exp_en > 0) chk({tag, ":en_start"}, first_en, 2);
    chk({tag, ":hit"}, res_hit, exp_hit);
    chk({tag, ":first"}, res_first, exp_first);
    chk({tag, ":hits"}, res_hits, exp_hits);
    chk({tag, ":aborted"}, res_aborted, exp_ab);
    chk({tag, ":cmp_done"}, ctr_cmp, mask);
    chk({tag, ":busy_done"}, busy, 0);
    chk({tag, ":en_done"}, ctr_en, 0);

    repeat ($urandom_range(0, 2)) begin
      abort = 1'($urandom_range(0, 1));
      ctr_z = 1'($urandom_range(0, 1));
      @(negedge CK);
      chk({tag, ":hold_valid"}, res_valid, 1);
      chk({tag, ":hold_hits"}, res_hits, exp_hits);
      chk({tag, ":hold_aborted"}, res_aborted, exp_ab);
    end

    res_ready = 1'b1;
    abort     = 1'b0;
    @(negedge CK);
    res_ready = 1'b0;
    chk({tag, ":valid_clr"}, res_valid, 0);
    chk({tag, ":ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    int en_cnt, guard, b, abi;
    bit stop, abl;
    RN = 1'b1;
    cmd_valid = 0; cmd_mask = '0; cmd_budget = '0; cmd_stop_on_hit = 0;
    abort = 0; ctr_z = 0; res_ready = 0;
    #2 RN = 1'b0;
    #2;
    chk("rst:en", ctr_en, 0);
    chk("rst:cmp", ctr_cmp, 0);
    chk("rst:busy", busy, 0);
    chk("rst:valid", res_valid, 0);
    chk("rst:hit", res_hit, 0);
    chk("rst:first", res_first, 0);
    chk("rst:hits", res_hits, 0);
    chk("rst:aborted", res_aborted, 0);
    repeat (2) @(negedge CK);
    RN = 1'b1;

    clear_pat(0);
    run_sweep('0, 5, 0, 0, -1, "t1");
    z_pat[3] = 1; z_pat[7] = 1;
    run_sweep(MASK_W'($urandom), 10, 0, 0, -1, "t2");
    run_sweep(MASK_W'($urandom), 10, 1, 0, -1, "t3");
    run_sweep(MASK_W'($urandom), 0, 0, 0, -1, "t4");
    clear_pat(0);
    z_pat[4] = 1;
    run_sweep(MASK_W'($urandom), 20, 0, 0, 4, "t5");
    run_sweep(MASK_W'($urandom), 7, 0, 1, -1, "t5_load_abort");

    repeat (3) begin
      @(negedge CK);
      abort = 1'b1;
      chk("idle_abort:ready", cmd_ready, 1);
      chk("idle_abort:busy", busy, 0);
      chk("idle_abort:valid", res_valid, 0);
    end
    abort = 1'b0;

    clear_pat(1);
    run_sweep(MASK_W'($urandom), 300, 0, 0, -1, "t6");

    @(negedge CK);
    cmd_valid = 1'b1; cmd_mask = MASK_W'($urandom); cmd_budget = 16'd300;
    cmd_stop_on_hit = 1'b0; ctr_z = 1'b1;
    @(negedge CK);
    cmd_valid = 1'b0;
    en_cnt = 0; guard = 0;
    while (en_cnt < 101 && guard < 200) begin
      @(negedge CK);
      guard++;
      if (ctr_en) en_cnt++;
    end
    chk("t6r:reached_idx100", en_cnt, 101);
    chk("t6r:hits_before", res_hits, 100);
    #1 RN = 1'b0;
    #1;
    chk("t6r:en", ctr_en, 0);
    chk("t6r:busy", busy, 0);
    chk("t6r:cmp", ctr_cmp, 0);
    chk("t6r:hits", res_hits, 0);
    chk("t6r:hit", res_hit, 0);
    chk("t6r:valid", res_valid, 0);
    chk("t6r:ready", cmd_ready, 1);
    @(negedge CK);
    RN = 1'b1;
    ctr_z = 1'b0;
    @(negedge CK);
    chk("t6r:idle_after", cmd_ready, 1);

    for (int it = 0; it < 30; it++) begin
      b = $urandom_range(0, 40);
      for (int i = 0; i < 512; i++) z_pat[i] = ($urandom_range(0, 3) == 0);
      stop = 1'($urandom_range(0, 1));
      abl  = ($urandom_range(0, 7) == 0);
      abi  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, b + 1)) : -1;
      run_sweep(MASK_W'($urandom), b, stop, abl, abi, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
